// File: rtl/nibble_serial_sub_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_sub_ctrl.
//   master : operand producer / result consumer side (drives in_*, out_ready)
//   slave  : the subtract sequencer (drives in_ready, out_*)
// Signals:
//   in_valid/in_ready    operand handshake
//   in_a, in_b           minuend / subtrahend (unsigned, WIDTH bits)
//   out_valid/out_ready  result handshake
//   out_diff             A - B modulo 2^WIDTH
//   out_borrow           1 when B > A
//   out_zero, out_ovf    only present when SUB_FLAGS_EN is defined
interface nibble_serial_sub_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_borrow;
`ifdef SUB_FLAGS_EN
  logic             out_zero;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_diff, out_borrow, out_zero, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_diff, out_borrow, out_zero, out_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_diff, out_borrow
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_diff, out_borrow
  );
`endif
endinterface

// File: rtl/nibble_serial_sub_ctrl.sv
// Nibble-serial subtract sequencer: computes A - B over WIDTH bits using one 4-bit subtract
// datapath, one nibble per cycle LSB->MSB with a chained borrow.
// FSM: StIdle (accept operands) -> StRun (NNIB cycles) -> StDone (hold result) -> StIdle.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   bus_io  nibble_serial_sub_ctrl_if.slave: operand and result valid/ready handshakes
// Optional feature macro SUB_FLAGS_EN adds registered out_zero / out_ovf result flags.
module nibble_serial_sub_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  nibble_serial_sub_ctrl_if.slave       bus_io
);

  localparam int unsigned NNIB = WIDTH / 4;
  localparam int unsigned IdxW = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam int unsigned Msb  = WIDTH - 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
`ifdef SUB_FLAGS_EN
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
`endif

  // Shared 4-bit datapath working on the nibble selected by idx_q.
  logic [IdxW+1:0]  nib_off;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       nib_t;
  logic             last_nib;

  assign nib_off  = {idx_q, 2'b00};
  assign a_nib    = a_q[nib_off +: 4];
  assign b_nib    = b_q[nib_off +: 4];
  // Bit 4 of the 5-bit difference is the borrow out of this nibble.
  assign nib_t    = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, borrow_q};
  assign last_nib = (idx_q == IdxW'(NNIB - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
`ifdef SUB_FLAGS_EN
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`endif

    case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          a_d      = bus_io.in_a;
          b_d      = bus_io.in_b;
          idx_d    = '0;
          borrow_d = 1'b0;
          state_d  = StRun;
        end
      end

      StRun: begin
        diff_d[nib_off +: 4] = nib_t[3:0];
        borrow_d             = nib_t[4];
        if (last_nib) begin
          state_d = StDone;
`ifdef SUB_FLAGS_EN
          // diff_d already holds the complete result on the last nibble.
          zero_d = (diff_d == '0);
          ovf_d  = (a_q[Msb] != b_q[Msb]) && (diff_d[Msb] != a_q[Msb]);
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      StDone: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
`ifdef SUB_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
`ifdef SUB_FLAGS_EN
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus_io.in_ready   = (state_q == StIdle);
  assign bus_io.out_valid  = (state_q == StDone);
  assign bus_io.out_diff   = diff_q;
  // After the last nibble the chained borrow is the final B > A indication.
  assign bus_io.out_borrow = borrow_q;
`ifdef SUB_FLAGS_EN
  assign bus_io.out_zero   = zero_q;
  assign bus_io.out_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Self-checking bench for nibble_serial_sub_ctrl (WIDTH=16). A negedge monitor pops the
// scoreboard on every result handshake; scenario tasks check timing and handshake behaviour.
module tb_nibble_serial_sub_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NNIB  = WIDTH / 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  nibble_serial_sub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic             ovf;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    e.diff   = a - b;
    e.borrow = (b > a);
    e.zero   = (e.diff == '0);
    e.ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (e.diff[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: a handshake completes on the next posedge when both are high here.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      exp_t e;
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_result: got diff=%h, required no result", bus.out_diff);
      end else begin
        e = sb_q.pop_front();
        if (bus.out_diff !== e.diff || bus.out_borrow !== e.borrow) begin
          miscompares++;
          $display("FAIL sb_result: got diff=%h borrow=%b, required diff=%h borrow=%b",
                   bus.out_diff, bus.out_borrow, e.diff, e.borrow);
        end
`ifdef SUB_FLAGS_EN
        vectors++;
        if (bus.out_zero !== e.zero || bus.out_ovf !== e.ovf) begin
          miscompares++;
          $display("FAIL sb_flags: got zero=%b ovf=%b, required zero=%b ovf=%b",
                   bus.out_zero, bus.out_ovf, e.zero, e.ovf);
        end
`endif
      end
    end
  end

  // Present an operand pair, wait for acceptance, push its expectation. Returns with the
  // bench one cycle past the accept cycle.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready=%b, required 1", bus.in_ready);
    end
    sb_q.push_back(model(a, b));
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = WIDTH'($urandom);
    bus.in_b     = WIDTH'($urandom);
  endtask

  // Wait for out_valid; lat counts cycles since the accept cycle (starts at 1 after issue).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (bus.out_valid !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL valid_timeout: out_valid=%b, required 1", bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hs: got in_ready=%b out_valid=%b, required 1 0",
               bus.in_ready, bus.out_valid);
    end
    vectors++;
    if (bus.out_diff !== 16'h0000 || bus.out_borrow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_result: got diff=%h borrow=%b, required 0000 0",
               bus.out_diff, bus.out_borrow);
    end
`ifdef SUB_FLAGS_EN
    vectors++;
    if (bus.out_zero !== 1'b0 || bus.out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got zero=%b ovf=%b, required 0 0", bus.out_zero, bus.out_ovf);
    end
`endif
  endtask

  task automatic test_basic_latency();
    int lat;
    issue(16'h1234, 16'h0234);
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL run_in_ready: got %b, required 0", bus.in_ready);
    end
    wait_valid(lat);
    vectors++;
    if (lat != NNIB + 1) begin
      miscompares++;
      $display("FAIL latency: got %0d cycles, required %0d", lat, NNIB + 1);
    end
    vectors++;
    if (bus.out_diff !== 16'h1000 || bus.out_borrow !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: got diff=%h borrow=%b, required 1000 0",
               bus.out_diff, bus.out_borrow);
    end
    tick();
  endtask

  task automatic test_borrow_chain();
    int lat;
    issue(16'h1000, 16'h0001);
    wait_valid(lat);
    tick();
    issue(16'h0000, 16'h0001);
    wait_valid(lat);
    vectors++;
    if (bus.out_diff !== 16'hFFFF || bus.out_borrow !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_result: got diff=%h borrow=%b, required ffff 1",
               bus.out_diff, bus.out_borrow);
    end
    tick();
    issue(16'hABCD, 16'hABCD);
    wait_valid(lat);
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    bus.out_ready = 1'b0;
    issue(16'h4321, 16'h1234);
    wait_valid(lat);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = (i == 1);
      bus.in_a     = 16'h7777;
      bus.in_b     = 16'h1111;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_diff !== 16'h30ED) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got valid=%b in_ready=%b diff=%h, required 1 0 30ed",
                 i, bus.out_valid, bus.in_ready, bus.out_diff);
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: got in_ready=%b out_valid=%b, required 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(16'h00FF, 16'h0100);
    wait_valid(lat);
    // Offer the next op during the result handshake; it must wait for IDLE.
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h9000;
    bus.in_b     = 16'h0FFF;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_done_ready: got %b, required 0", bus.in_ready);
    end
    tick();
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_idle_ready: got %b, required 1", bus.in_ready);
    end
    issue(16'h9000, 16'h0FFF);
    wait_valid(lat);
    vectors++;
    if (lat != NNIB + 1) begin
      miscompares++;
      $display("FAIL b2b_latency: got %0d, required %0d", lat, NNIB + 1);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int lat;
    bit saw_valid = 1'b0;
    issue(16'hFFFF, 16'h0001);
    tick();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_diff !== 16'h0000 ||
        bus.out_borrow !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_reset_vals: got rdy=%b vld=%b diff=%h brw=%b, required 1 0 0000 0",
               bus.in_ready, bus.out_valid, bus.out_diff, bus.out_borrow);
    end
    sb_q.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid !== 1'b0) saw_valid = 1'b1;
      tick();
    end
    vectors++;
    if (saw_valid) begin
      miscompares++;
      $display("FAIL abort_no_valid: got out_valid pulse, required none");
    end
    issue(16'h0005, 16'h0003);
    wait_valid(lat);
    vectors++;
    if (bus.out_diff !== 16'h0002 || bus.out_borrow !== 1'b0) begin
      miscompares++;
      $display("FAIL post_abort_result: got diff=%h borrow=%b, required 0002 0",
               bus.out_diff, bus.out_borrow);
    end
    tick();
  endtask

`ifdef SUB_FLAGS_EN
  task automatic test_flags();
    int lat;
    issue(16'h8000, 16'h0001);
    wait_valid(lat);
    vectors++;
    if (bus.out_diff !== 16'h7FFF || bus.out_ovf !== 1'b1 || bus.out_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL flags_ovf: got diff=%h ovf=%b zero=%b, required 7fff 1 0",
               bus.out_diff, bus.out_ovf, bus.out_zero);
    end
    tick();
    issue(16'h5555, 16'h5555);
    wait_valid(lat);
    vectors++;
    if (bus.out_diff !== 16'h0000 || bus.out_zero !== 1'b1 || bus.out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL flags_zero: got diff=%h zero=%b ovf=%b, required 0000 1 0",
               bus.out_diff, bus.out_zero, bus.out_ovf);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_latency();
    test_borrow_chain();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
`ifdef SUB_FLAGS_EN
    test_flags();
`endif
    tick();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending results, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
